// File: rtl/apb2axi_cmd_arb.sv
// Per-channel command FIFOs feeding one downstream port through a registered round-robin grant,
// with per-channel outstanding-command limits. Define APB2AXI_CMD_ARB_STRICT_PRIO_EN for fixed priority.
module apb2axi_cmd_arb #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ENTRY_W   = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_CH-1:0]           push_vld,
  output logic [NUM_CH-1:0]           push_rdy,
  input  logic [NUM_CH*ENTRY_W-1:0]   push_data,
  output logic                        pop_vld,
  input  logic                        pop_rdy,
  output logic [ENTRY_W-1:0]          pop_data,
  output logic [$clog2(NUM_CH)-1:0]   pop_ch,
  input  logic                        cpl_vld,
  input  logic [$clog2(NUM_CH)-1:0]   cpl_ch,
  output logic [NUM_CH*4-1:0]         outst_cnt,
  output logic                        cpl_err
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {StIdle, StGrant} state_e;

  logic [ENTRY_W-1:0] mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0]   wptr_q [NUM_CH];
  logic [PTR_W-1:0]   wptr_d [NUM_CH];
  logic [PTR_W-1:0]   rptr_q [NUM_CH];
  logic [PTR_W-1:0]   rptr_d [NUM_CH];
  logic [PTR_W:0]     cnt_q  [NUM_CH];
  logic [PTR_W:0]     cnt_d  [NUM_CH];
  logic [3:0]         outst_q [NUM_CH];
  logic [3:0]         outst_d [NUM_CH];

  logic [NUM_CH-1:0] full, push_en, pop_en, cpl_en, elig_d;
  logic              cpl_err_q, cpl_err_d;
  logic [CH_W-1:0]   rr_q, rr_d, grant_ch_q, grant_ch_d, sel_ch, idx;
  logic              sel_vld, hs;
  state_e            state_q, state_d;

  // FIFO and outstanding-count next state, plus next-cycle eligibility
  always_comb begin
    hs        = (state_q == StGrant) && pop_rdy;
    cpl_err_d = cpl_err_q;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]     = (cnt_q[c] == (PTR_W+1)'(DEPTH));
      push_rdy[c] = aresetn && !full[c];
      push_en[c]  = push_vld[c] && !full[c];
      pop_en[c]   = hs && (grant_ch_q == CH_W'(c));
      cpl_en[c]   = cpl_vld && (cpl_ch == CH_W'(c)) && (outst_q[c] != 4'd0);
      if (cpl_vld && (cpl_ch == CH_W'(c)) && (outst_q[c] == 4'd0)) cpl_err_d = 1'b1;
      wptr_d[c]   = wptr_q[c] + PTR_W'(push_en[c]);
      rptr_d[c]   = rptr_q[c] + PTR_W'(pop_en[c]);
      cnt_d[c]    = cnt_q[c] + (PTR_W+1)'(push_en[c]) - (PTR_W+1)'(pop_en[c]);
      outst_d[c]  = outst_q[c] + 4'(pop_en[c]) - 4'(cpl_en[c]);
      elig_d[c]   = (cnt_d[c] != '0) && (outst_d[c] < 4'(MAX_OUTST));
    end
  end

  // Selection looks at next-cycle state so a grant can be registered in the push cycle's edge
  always_comb begin
    int unsigned start;
    rr_d = rr_q;
    if (hs) rr_d = (grant_ch_q == CH_W'(NUM_CH - 1)) ? '0 : grant_ch_q + CH_W'(1);
`ifdef APB2AXI_CMD_ARB_STRICT_PRIO_EN
    start = 0;
`else
    start = int'(rr_d);
`endif
    sel_vld = 1'b0;
    sel_ch  = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((start + i) % NUM_CH);
      if (!sel_vld && elig_d[idx]) begin
        sel_vld = 1'b1;
        sel_ch  = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    unique case (state_q)
      StIdle: begin
        if (sel_vld) begin
          state_d    = StGrant;
          grant_ch_d = sel_ch;
        end
      end
      StGrant: begin
        if (hs) begin
          if (sel_vld) grant_ch_d = sel_ch;
          else         state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop_vld  = (state_q == StGrant);
    pop_ch   = grant_ch_q;
    pop_data = pop_vld ? mem_q[grant_ch_q][rptr_q[grant_ch_q]] : '0;
    cpl_err  = cpl_err_q;
    for (int c = 0; c < NUM_CH; c++) outst_cnt[c*4 +: 4] = outst_q[c];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      grant_ch_q <= '0;
      rr_q       <= '0;
      cpl_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      rr_q       <= rr_d;
      cpl_err_q  <= cpl_err_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        cnt_q[c]   <= '0;
        outst_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        cnt_q[c]   <= cnt_d[c];
        outst_q[c] <= outst_d[c];
      end
    end
  end

  // Storage is not reset; cleared pointers make stale entries unreachable
  always_ff @(posedge aclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_en[c]) mem_q[c][wptr_q[c]] <= push_data[c*ENTRY_W +: ENTRY_W];
    end
  end

endmodule

// File: tb/tb_apb2axi_cmd_arb.sv
// Bench for apb2axi_cmd_arb: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic against a queue-based reference model.
module tb_apb2axi_cmd_arb;
  localparam int NCH = 2;
  localparam int EW  = 64;
  localparam int DP  = 4;
  localparam int MO  = 2;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [1:0]     push_vld, push_rdy;
  logic [127:0]   push_data;
  logic           pop_vld, pop_rdy;
  logic [63:0]    pop_data;
  logic [0:0]     pop_ch, cpl_ch;
  logic           cpl_vld, cpl_err;
  logic [7:0]     outst_cnt;

  always #5 aclk = ~aclk;

  apb2axi_cmd_arb #(.NUM_CH(NCH), .ENTRY_W(EW), .DEPTH(DP), .MAX_OUTST(MO)) dut (
    .aclk(aclk), .aresetn(aresetn), .push_vld(push_vld), .push_rdy(push_rdy),
    .push_data(push_data), .pop_vld(pop_vld), .pop_rdy(pop_rdy), .pop_data(pop_data),
    .pop_ch(pop_ch), .cpl_vld(cpl_vld), .cpl_ch(cpl_ch), .outst_cnt(outst_cnt),
    .cpl_err(cpl_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] pv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       pr;
    logic       cv;
    logic       cc;
    logic       ev;
    logic       ech;
    logic [7:0] ed;
    logic [7:0] eo;
    logic       ee;
    logic [1:0] er;
  } vec_t;
  vec_t tbl[7];

  // Reference model: plain queues and counters
  logic [63:0] mq0[$];
  logic [63:0] mq1[$];
  int m_out[2];
  int m_rr;
  int m_ch;
  bit m_vld;
  bit m_err;

  function automatic int qsize(input int c);
    return (c == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [63:0] qhead(input int c);
    return (c == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic void m_reset();
    mq0.delete(); mq1.delete();
    m_out[0] = 0; m_out[1] = 0;
    m_rr = 0; m_ch = 0; m_vld = 0; m_err = 0;
  endfunction

  function automatic void m_pick();
    int start;
    int c;
`ifdef APB2AXI_CMD_ARB_STRICT_PRIO_EN
    start = 0;
`else
    start = m_rr;
`endif
    m_vld = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (start + i) % NCH;
      if (!m_vld && qsize(c) > 0 && m_out[c] < MO) begin
        m_vld = 1;
        m_ch  = c;
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs held during the cycle
  function automatic void m_step();
    bit hs;
    int oo[2];
    bit fl[2];
    hs = m_vld && pop_rdy;
    oo[0] = m_out[0]; oo[1] = m_out[1];
    fl[0] = mq0.size() >= DP; fl[1] = mq1.size() >= DP;
    if (push_vld[0] && !fl[0]) mq0.push_back(push_data[63:0]);
    if (push_vld[1] && !fl[1]) mq1.push_back(push_data[127:64]);
    if (hs) begin
      if (m_ch == 0) void'(mq0.pop_front());
      else           void'(mq1.pop_front());
      m_out[m_ch]++;
      m_rr = (m_ch + 1) % NCH;
    end
    if (cpl_vld) begin
      if (oo[cpl_ch] == 0) m_err = 1;
      else                 m_out[cpl_ch]--;
    end
    if (!m_vld || hs) m_pick();
  endfunction

  task automatic idle_inputs();
    push_vld = '0; push_data = '0; pop_rdy = 1'b0; cpl_vld = 1'b0; cpl_ch = '0;
  endtask

  task automatic next_cyc();
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 1'b0;
    m_reset();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  initial begin
    tbl[0] = '{2'b11, 8'h10, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b11};
    tbl[1] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 2'b11};
    tbl[2] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h01, 1'b0, 2'b11};
    tbl[3] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 2'b11};
    tbl[4] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 2'b11};
    tbl[5] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b11};
    tbl[6] = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 2'b11};

    idle_inputs();
    aresetn = 1'b0;
    #12;
    chk("rst_pop_vld", 64'(pop_vld), 64'd0);
    chk("rst_pop_ch", 64'(pop_ch), 64'd0);
    chk("rst_pop_data", pop_data, 64'd0);
    chk("rst_push_rdy", 64'(push_rdy), 64'd0);
    chk("rst_outst", 64'(outst_cnt), 64'd0);
    chk("rst_cpl_err", 64'(cpl_err), 64'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_push_rdy", 64'(push_rdy), 64'h3);
    next_cyc();

    // Two-channel round robin, completions and the zero-outstanding completion error
    for (int i = 0; i < 7; i++) begin
      push_vld  = tbl[i].pv;
      push_data = {56'h0, tbl[i].d1, 56'h0, tbl[i].d0};
      pop_rdy   = tbl[i].pr;
      cpl_vld   = tbl[i].cv;
      cpl_ch    = tbl[i].cc;
      @(negedge aclk);
      chk($sformatf("tbl%0d_pop_vld", i), 64'(pop_vld), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pop_ch", i), 64'(pop_ch), 64'(tbl[i].ech));
        chk($sformatf("tbl%0d_pop_data", i), pop_data, 64'(tbl[i].ed));
      end
      chk($sformatf("tbl%0d_outst", i), 64'(outst_cnt), 64'(tbl[i].eo));
      chk($sformatf("tbl%0d_cpl_err", i), 64'(cpl_err), 64'(tbl[i].ee));
      chk($sformatf("tbl%0d_push_rdy", i), 64'(push_rdy), 64'(tbl[i].er));
      next_cyc();
    end
    idle_inputs();

    // Fill ch0, full/ready behaviour, then the outstanding limit
    for (int k = 0; k < 4; k++) begin
      push_vld = 2'b01;
      push_data = {64'h0, 64'(32'h20 + k)};
      next_cyc();
    end
    push_vld = 2'b00;
    pop_rdy  = 1'b1;
    @(negedge aclk);
    chk("full_push_rdy0", 64'(push_rdy[0]), 64'd0);
    chk("full_pop_vld", 64'(pop_vld), 64'd1);
    chk("full_pop_data", pop_data, 64'h20);
    next_cyc();
    pop_rdy = 1'b0;
    @(negedge aclk);
    chk("afterpop_push_rdy0", 64'(push_rdy[0]), 64'd1);
    chk("afterpop_pop_data", pop_data, 64'h21);
    chk("afterpop_outst", 64'(outst_cnt), 64'h01);
    next_cyc();
    pop_rdy = 1'b1;
    next_cyc();
    @(negedge aclk);
    chk("limit_pop_vld", 64'(pop_vld), 64'd0);
    chk("limit_outst", 64'(outst_cnt), 64'h02);
    next_cyc();
    cpl_vld = 1'b1; cpl_ch = 1'b0;
    @(negedge aclk);
    chk("limit_hold_pop_vld", 64'(pop_vld), 64'd0);
    next_cyc();
    cpl_vld = 1'b0; pop_rdy = 1'b0;
    @(negedge aclk);
    chk("regrant_pop_vld", 64'(pop_vld), 64'd1);
    chk("regrant_pop_ch", 64'(pop_ch), 64'd0);
    chk("regrant_pop_data", pop_data, 64'h22);
    chk("regrant_outst", 64'(outst_cnt), 64'h01);
    next_cyc();
    push_vld = 2'b01; push_data = {64'h0, 64'h24};
    next_cyc();
    push_vld = 2'b00;

    // Asynchronous reset with three entries queued
    aresetn = 1'b0;
    #1;
    chk("midrst_pop_vld", 64'(pop_vld), 64'd0);
    chk("midrst_push_rdy", 64'(push_rdy), 64'd0);
    chk("midrst_outst", 64'(outst_cnt), 64'd0);
    chk("midrst_cpl_err", 64'(cpl_err), 64'd0);
    next_cyc();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("postrst_push_rdy", 64'(push_rdy), 64'h3);
    chk("postrst_pop_vld", 64'(pop_vld), 64'd0);
    chk("postrst_outst", 64'(outst_cnt), 64'd0);
    next_cyc();
    @(negedge aclk);
    chk("postrst_empty", 64'(pop_vld), 64'd0);
    next_cyc();

    // Stalled grant must hold steady
    push_vld = 2'b10; push_data = {64'hA5, 64'h0};
    next_cyc();
    push_vld = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk($sformatf("stall%0d_pop_vld", k), 64'(pop_vld), 64'd1);
      chk($sformatf("stall%0d_pop_ch", k), 64'(pop_ch), 64'd1);
      chk($sformatf("stall%0d_pop_data", k), pop_data, 64'hA5);
      next_cyc();
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      push_vld  = 2'($urandom_range(0, 3));
      push_data = {$urandom, $urandom, $urandom, $urandom};
      pop_rdy   = ($urandom_range(0, 3) != 0);
      cpl_vld   = ($urandom_range(0, 2) == 0);
      cpl_ch    = 1'($urandom_range(0, 1));
      @(negedge aclk);
      chk("rnd_pop_vld", 64'(pop_vld), 64'(m_vld));
      if (m_vld) begin
        chk("rnd_pop_ch", 64'(pop_ch), 64'(m_ch));
        chk("rnd_pop_data", pop_data, qhead(m_ch));
      end
      chk("rnd_push_rdy", 64'(push_rdy), 64'({qsize(1) < DP, qsize(0) < DP}));
      chk("rnd_outst", 64'(outst_cnt), 64'({4'(m_out[1]), 4'(m_out[0])}));
      chk("rnd_cpl_err", 64'(cpl_err), 64'(m_err));
      @(posedge aclk);
      m_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb2axi_cmd_arb.md
APB2AXI_CMD_ARB -- requirements
Module: apb2axi_cmd_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of command channels (2..8).
REQ-002 SHALL have parameter ENTRY_W, default 64: command entry width in bits.
REQ-003 SHALL have parameter DEPTH, default 4: per-channel FIFO depth (power of two, 2..16).
REQ-004 SHALL have parameter MAX_OUTST, default 8: per-channel outstanding-command limit (1..15).
REQ-005 SHALL have port aclk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port push_vld, input, NUM_CH: per-channel push valid.
REQ-008 SHALL have port push_rdy, output, NUM_CH: per-channel push ready (FIFO not full).
REQ-009 SHALL have port push_data, input, NUM_CH*ENTRY_W: channel c occupies bits [c*ENTRY_W +: ENTRY_W].
REQ-010 SHALL have port pop_vld, input/output as output, 1: granted command valid.
REQ-011 SHALL have port pop_rdy, input, 1: downstream builder ready.
REQ-012 SHALL have port pop_data, output, ENTRY_W: head entry of granted channel.
REQ-013 SHALL have port pop_ch, output, $clog2(NUM_CH): granted channel index.
REQ-014 SHALL have port cpl_vld, input, 1: one command of channel cpl_ch completed.
REQ-015 SHALL have port cpl_ch, input, $clog2(NUM_CH): completing channel index.
REQ-016 SHALL have port outst_cnt, output, NUM_CH*4: per-channel outstanding count.
REQ-017 SHALL have port cpl_err, output, 1: sticky flag, completion received with zero outstanding.

Function
REQ-018 SHALL push entry into channel c FIFO when push_vld[c] && push_rdy[c]; push_rdy[c] = !full[c], independent of pop in same cycle.
REQ-019 SHALL make a pushed entry eligible for grant no earlier than the following cycle (1-cycle minimum push-to-pop_vld latency).
REQ-020 SHALL treat channel c eligible when FIFO non-empty and outst_cnt[c] < MAX_OUTST.
REQ-021 SHALL select among eligible channels round-robin, searching from rr_ptr upward with wrap from NUM_CH-1 to 0.
REQ-022 SHALL register grant in a two-state FSM: IDLE (no grant; pop_vld=0) -> GRANT when any channel eligible; GRANT -> IDLE on pop handshake when no channel eligible next, else stays GRANT with new selection.
REQ-023 SHALL hold pop_vld, pop_data, pop_ch stable while pop_vld && !pop_rdy; no re-arbitration until handshake.
REQ-024 SHALL on pop handshake pop the granted FIFO, set rr_ptr to pop_ch+1 (wrap), and increment outst_cnt[pop_ch].
REQ-025 SHALL allow back-to-back handshakes every cycle when eligible channels exist.
REQ-026 SHALL decrement outst_cnt[cpl_ch] on cpl_vld; simultaneous handshake and completion on the same channel leaves count unchanged.
REQ-027 SHALL ignore cpl_vld when outst_cnt[cpl_ch] is 0 and set cpl_err; cpl_err clears only on reset.
REQ-028 SHALL accept simultaneous push and pop on the same FIFO, level unchanged; pointers wrap modulo DEPTH.
REQ-029 SHALL never return pop_data of an empty FIFO; pop_vld requires granted FIFO non-empty.

Reset
REQ-030 SHALL on aresetn low immediately clear all FIFO pointers, rr_ptr=0, FSM=IDLE, outst_cnt=0, cpl_err=0.
REQ-031 SHALL drive pop_vld=0, pop_ch=0, pop_data=0, push_rdy=0 during reset, push_rdy all-ones first cycle after release.
REQ-032 SHALL discard in-flight entries and grants when reset asserts mid-operation.

Configuration
REQ-033 SHALL, with macro APB2AXI_CMD_ARB_STRICT_PRIO_EN defined, use fixed priority (lowest eligible index wins, rr_ptr unused); without it, round-robin per REQ-021.

Verification
REQ-034 SHALL cover: NUM_CH=2, both channels push one entry cycle 0, pop_rdy=1 -> pops ch0 cycle 1, ch1 cycle 2.
REQ-035 SHALL cover: ch0 pushes 4 entries DEPTH=4 -> push_rdy[0]=0; one pop -> push_rdy[0]=1 next cycle.
REQ-036 SHALL cover: pop_rdy=0 for 5 cycles with grant ch1 data 0xA5 -> pop_vld, pop_ch=1, pop_data=0xA5 stable throughout.
REQ-037 SHALL cover: MAX_OUTST=2, ch0 pops 2 without completion -> ch0 ineligible; cpl_vld cpl_ch=0 -> ch0 granted again.
REQ-038 SHALL cover: cpl_vld cpl_ch=1 with outst_cnt[1]=0 -> cpl_err=1, count stays 0.
REQ-039 SHALL cover: aresetn low mid-burst with 3 entries queued -> pop_vld=0 immediately, all counts 0 after release.
